// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter with a clock-enable divider, a STOP/RUN
// state machine, synchronous clear and a validated BCD preset load.
module bcd2_counter #(
    parameter int unsigned DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       tick,
    output logic       wrap,
    output logic       running
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       tens_q;
    logic [3:0]       ones_q;
    logic             tick_q;
    logic             wrap_q;

    logic [3:0]       tens_d;
    logic [3:0]       ones_d;
    logic             wrap_d;
    logic             load_ok;
    logic             div_last;

    // A preset is only accepted when both nibbles are legal BCD digits.
    assign load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    assign div_last = (div_q == DIV_LAST);

    // Digit values after one count step in the requested direction.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        wrap_d = 1'b0;
        if (up) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else begin
                ones_d = 4'd0;
                if (tens_q >= 4'd9) begin
                    tens_d = 4'd0;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end
        end else begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                if (tens_q == 4'd0) begin
                    tens_d = 4'd9;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q - 4'd1;
                end
            end
        end
    end

    // FSM, divider and digit registers; priority rst > clear > load > step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (clear) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (start_stop) begin
                state_q <= (state_q == ST_RUN) ? ST_STOP : ST_RUN;
            end
            if (load) begin
                // An illegal preset is dropped but still swallows any step.
                if (load_ok) begin
                    tens_q <= load_val[7:4];
                    ones_q <= load_val[3:0];
                    div_q  <= '0;
                end
            end else if (state_q == ST_RUN) begin
                if (div_last) begin
                    div_q  <= '0;
                    tens_q <= tens_d;
                    ones_q <= ones_d;
                    tick_q <= 1'b1;
                    wrap_q <= wrap_d;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    assign digit1  = tens_q;
    assign digit0  = ones_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_bcd2_counter.sv
// Bench for bcd2_counter (DIV=4): directed scenarios then random traffic,
// checked every cycle against a counter model kept as an integer 0..99.
module tb_bcd2_counter;

    localparam int unsigned DIV = 4;

    logic       clk;
    logic       rst;
    logic       start_stop;
    logic       clear;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       tick;
    logic       wrap;
    logic       running;

    bcd2_counter #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .clear     (clear),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .digit1    (digit1),
        .digit0    (digit0),
        .tick      (tick),
        .wrap      (wrap),
        .running   (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference state: counter value as a number, phase within DIV, run flag.
    int m_val;
    int m_div;
    bit m_run;
    bit m_tick;
    bit m_wrap;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val  = 0;
        m_div  = 0;
        m_run  = 1'b0;
        m_tick = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic model_edge(input bit ss, input bit clr, input bit u,
                              input bit ld, input logic [7:0] lv);
        int tens, ones;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            tens = int'(lv[7:4]);
            ones = int'(lv[3:0]);
            if (ld) begin
                if (tens <= 9 && ones <= 9) begin
                    m_val = tens * 10 + ones;
                    m_div = 0;
                end
            end else if (m_run) begin
                if (m_div == int'(DIV) - 1) begin
                    m_div  = 0;
                    m_tick = 1'b1;
                    if (u) begin
                        m_wrap = (m_val == 99);
                        m_val  = (m_val + 1) % 100;
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = (m_val + 99) % 100;
                    end
                end else begin
                    m_div = m_div + 1;
                end
            end
            if (ss) m_run = !m_run;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".digit1"},  8'(digit1),  8'(m_val / 10));
        chk({tag, ".digit0"},  8'(digit0),  8'(m_val % 10));
        chk({tag, ".tick"},    8'(tick),    8'(m_tick));
        chk({tag, ".wrap"},    8'(wrap),    8'(m_wrap));
        chk({tag, ".running"}, 8'(running), 8'(m_run));
    endtask

    // One clock: drive inputs, advance model at the edge, check 1ns later.
    task automatic cyc(input string tag, input bit ss, input bit clr, input bit u,
                       input bit ld, input logic [7:0] lv);
        start_stop = ss;
        clear      = clr;
        up         = u;
        load       = ld;
        load_val   = lv;
        @(posedge clk);
        model_edge(ss, clr, u, ld, lv);
        #1;
        check_all(tag);
        start_stop = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
    endtask

    task automatic idle(input string tag, input bit u, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, u, 1'b0, 8'h00);
    endtask

    // Idle until the model sits one edge before a step (bounded).
    task automatic to_step_edge(input string tag, input bit u);
        int guard = 0;
        while (!(m_run && m_div == int'(DIV) - 1) && guard < 16) begin
            cyc(tag, 1'b0, 1'b0, u, 1'b0, 8'h00);
            guard++;
        end
        chk({tag, ".reach_step"}, 8'(guard < 16), 8'd1);
    endtask

    int nticks;
    int nwraps;
    int r;
    bit rss, rclr, rld, ru;
    logic [7:0] rlv;

    initial begin
        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        up         = 1'b1;
        load       = 1'b0;
        load_val   = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        idle("post_reset", 1'b1, 3);

        // Twelve up steps from 00 take 48 cycles after the start pulse.
        nticks = 0;
        nwraps = 0;
        cyc("start", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 48; i++) begin
            cyc("up12", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            if (tick === 1'b1) nticks++;
            if (wrap === 1'b1) nwraps++;
        end
        chk("up12.ticks", 8'(nticks), 8'd12);
        chk("up12.wraps", 8'(nwraps), 8'd0);
        chk("up12.d1", 8'(digit1), 8'd1);
        chk("up12.d0", 8'(digit0), 8'd2);

        // Preset 98, count up through 99 into 00 with a single wrap pulse.
        cyc("clr1", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        cyc("ld98", 1'b1, 1'b0, 1'b1, 1'b1, 8'h98);
        nwraps = 0;
        for (int i = 0; i < 12; i++) begin
            cyc("up98", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            if (wrap === 1'b1) nwraps++;
        end
        chk("up98.wraps", 8'(nwraps), 8'd1);

        // Preset 10, count down through 00 into 99.
        cyc("clr2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("ld10", 1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
        nwraps = 0;
        for (int i = 0; i < 48; i++) begin
            cyc("dn10", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            if (wrap === 1'b1) nwraps++;
        end
        chk("dn10.wraps", 8'(nwraps), 8'd1);
        chk("dn10.d1", 8'(digit1), 8'd9);

        // Illegal preset is ignored; legal preset on a step edge kills the step.
        idle("pre3a", 1'b1, 2);
        cyc("ld3a", 1'b0, 1'b0, 1'b1, 1'b1, 8'h3A);
        to_step_edge("pre25", 1'b1);
        cyc("ld25", 1'b0, 1'b0, 1'b1, 1'b1, 8'h25);
        chk("ld25.tick", 8'(tick), 8'd0);
        idle("post25", 1'b1, 6);

        // Stop on a step edge, sit idle, then resume with the divider intact.
        to_step_edge("prestop", 1'b1);
        cyc("stop_on_step", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        idle("stopped", 1'b1, 5);
        idle("midphase", 1'b1, 0);
        cyc("resume", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        idle("resumed", 1'b1, 2);
        cyc("stop2", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        idle("stopped2", 1'b1, 3);
        cyc("resume2", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        idle("resumed2", 1'b1, 6);

        // Asynchronous reset between edges while running.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst = 1'b0;
        idle("after_rst", 1'b1, 4);

        // Random traffic: rare clear/toggle, occasional loads (some illegal).
        for (int i = 0; i < 1500; i++) begin
            r    = int'($urandom_range(0, 99));
            rss  = (r < 5);
            rclr = (r == 50);
            rld  = (r >= 92);
            ru   = ($urandom_range(0, 9) < 7) ? up : ~up;
            if ($urandom_range(0, 1) == 0)
                rlv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                rlv = 8'($urandom);
            cyc("rand", rss, rclr, ru, rld, rlv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
